rca_serial_sub: RTL and testbench
=================================

RCA_SERIAL_SUB -- requirements
Module: rca_serial_sub

Interface
REQ-001 The block SHALL have one parameter: n, default 4, operand width in bits (legal n >= 1).
REQ-002 The block SHALL use one clock; reset is synchronous and active-high.
REQ-003 Port: clk  input  1  rising-edge clock.
REQ-004 Port: reset  input  1  synchronous active-high reset.
REQ-005 Port: start  input  1  request to begin a subtraction; sampled each rising edge.
REQ-006 Port: x  input  n  minuend; sampled only on the accepting edge.
REQ-007 Port: y  input  n  subtrahend; sampled only on the accepting edge.
REQ-008 Port: b_in  input  1  borrow-in; sampled only on the accepting edge.
REQ-009 Port: d  output  n  registered difference of the last completed operation.
REQ-010 Port: b_out  output  1  registered borrow-out of the last completed operation.
REQ-011 Port: busy  output  1  high while an operation is in progress.
REQ-012 Port: done  output  1  one-cycle pulse marking a new valid d/b_out.

Function
REQ-013 The block SHALL compute {b_out,d} such that d = (x - y - b_in) mod 2^n and b_out = 1 iff x < y + b_in (unsigned).
REQ-014 The block SHALL use one full-subtractor stage, one bit per cycle, LSB first: diff = x_k ^ y_k ^ b; next b = (~x_k & y_k) | (~(x_k ^ y_k) & b).
REQ-015 The block SHALL implement FSM states IDLE, RUN, DONE.
REQ-016 IDLE: start=1 -> latch x, y, b_in into working registers, clear bit counter, go to RUN; start=0 -> stay.
REQ-017 RUN: each edge processes one bit and increments counter; on the edge processing bit n-1, load d/b_out from the working result and go to DONE.
REQ-018 DONE: lasts exactly one cycle; start=1 -> accept new operands as in IDLE and go to RUN; else go to IDLE.
REQ-019 Latency: start accepted at edge E -> d/b_out updated and done=1 after edge E+n; done low after edge E+n+1.
REQ-020 busy SHALL be 1 exactly when state is RUN; done SHALL be 1 exactly when state is DONE.
REQ-021 start while in RUN SHALL be ignored; operands and the in-flight result are unaffected.
REQ-022 d and b_out SHALL hold their value from the previous completion throughout RUN and IDLE and change only on the edge entering DONE.
REQ-023 The bit counter SHALL be ceil(log2(n))-bit wide minimum (1 bit when n=1); with n=1 the operation SHALL complete in one RUN cycle.
REQ-024 Input changes on x, y, b_in outside the accepting edge SHALL have no effect.

Reset
REQ-025 reset=1 at a rising edge SHALL force state IDLE, d=0, b_out=0, busy=0, done=0, counter and working registers 0.
REQ-026 Reset SHALL take priority over start and over any in-flight operation; an aborted operation SHALL produce no done pulse.
REQ-027 start asserted together with reset SHALL be ignored; first acceptance possible on the next edge with reset=0.

Configuration
REQ-028 Macro RCA_SERIAL_SUB_CLAMP_EN SHALL select underflow clamping.
REQ-029 With RCA_SERIAL_SUB_CLAMP_EN defined: when final borrow is 1, d SHALL load 0 (b_out still 1); otherwise d is the modular difference.
REQ-030 Without RCA_SERIAL_SUB_CLAMP_EN: d SHALL always be the modular difference per REQ-013.

Verification (n=4)
REQ-031 reset 1 cycle, then x=5,y=3,b_in=0,start pulse at edge E -> busy E+1..E+4, done after E+4, d=2, b_out=0.
REQ-032 x=3,y=5,b_in=0 -> b_out=1; d=14 without macro, d=0 with RCA_SERIAL_SUB_CLAMP_EN.
REQ-033 x=0,y=0,b_in=1 -> d=15 (0 when clamped), b_out=1; x=15,y=15,b_in=0 -> d=0, b_out=0.
REQ-034 start=1 held continuously with new operands during RUN -> RUN not restarted, first result correct, second op accepted in DONE, done pulses every n+1 cycles.
REQ-035 reset asserted at the second RUN cycle -> next edge IDLE, d=0, b_out=0, no done pulse; subsequent 9-4 -> d=5, b_out=0.
REQ-036 After completion, change x/y with start=0 for 10 cycles -> d, b_out stable, done=0, busy=0.

Source files
------------

// File: rtl/rca_serial_sub_if.sv
// Operand/result bundle for rca_serial_sub.
// Signals:
//   start  - request to begin a subtraction (master -> slave)
//   x, y   - minuend / subtrahend, n bits (master -> slave)
//   b_in   - borrow-in (master -> slave)
//   d      - registered difference of last completed operation (slave -> master)
//   b_out  - registered borrow-out of last completed operation (slave -> master)
//   busy   - operation in progress (slave -> master)
//   done   - one-cycle pulse marking a new valid d/b_out (slave -> master)
interface rca_serial_sub_if #(
    parameter int unsigned n = 4
);
    logic         start;
    logic [n-1:0] x;
    logic [n-1:0] y;
    logic         b_in;
    logic [n-1:0] d;
    logic         b_out;
    logic         busy;
    logic         done;

    modport master (
        output start, x, y, b_in,
        input  d, b_out, busy, done
    );

    modport slave (
        input  start, x, y, b_in,
        output d, b_out, busy, done
    );
endinterface

// File: rtl/rca_serial_sub.sv
// Bit-serial subtractor: one full-subtractor stage, one bit per clock, LSB first.
// Computes d = (x - y - b_in) mod 2^n and b_out = (x < y + b_in).
// Ports:
//   clk    - rising-edge clock
//   reset  - synchronous active-high reset
//   bus    - rca_serial_sub_if.slave (start, x, y, b_in in; d, b_out, busy, done out)
// Configuration:
//   RCA_SERIAL_SUB_CLAMP_EN - when defined, an underflowing result loads d = 0
//                             (b_out still reports the borrow).
module rca_serial_sub #(
    parameter int unsigned n = 4
) (
    input  logic              clk,
    input  logic              reset,
    rca_serial_sub_if.slave   bus
);

    localparam int unsigned CW = (n > 1) ? $clog2(n) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [n-1:0]  x_q, x_d;
    logic [n-1:0]  y_q, y_d;
    logic          b_q, b_d;
    logic [n-1:0]  res_q, res_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [n-1:0]  d_q, d_d;
    logic          bout_q, bout_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    logic          diff_c;
    logic          b_next_c;
    logic [n-1:0]  res_shift_c;
    logic [n-1:0]  d_final_c;

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            b_q     <= 1'b0;
            res_q   <= '0;
            cnt_q   <= '0;
            d_q     <= '0;
            bout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            b_q     <= b_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            d_q     <= d_d;
            bout_q  <= bout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Full-subtractor on the current LSB; result bits enter at the MSB so the
    // word is aligned after n shifts.
    always_comb begin
        diff_c      = x_q[0] ^ y_q[0] ^ b_q;
        b_next_c    = (~x_q[0] & y_q[0]) | (~(x_q[0] ^ y_q[0]) & b_q);
        res_shift_c = res_q >> 1;
        res_shift_c[n-1] = diff_c;
`ifdef RCA_SERIAL_SUB_CLAMP_EN
        d_final_c   = b_next_c ? '0 : res_shift_c;
`else
        d_final_c   = res_shift_c;
`endif
    end

    // Next-state and datapath control
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        b_d     = b_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        d_d     = d_q;
        bout_d  = bout_q;

        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (bus.start) begin
                    x_d     = bus.x;
                    y_d     = bus.y;
                    b_d     = bus.b_in;
                    res_d   = '0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                // start is ignored here; operands already live in x_q/y_q
                x_d   = x_q >> 1;
                y_d   = y_q >> 1;
                b_d   = b_next_c;
                res_d = res_shift_c;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(n - 1)) begin
                    d_d     = d_final_c;
                    bout_d  = b_next_c;
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    assign bus.d     = d_q;
    assign bus.b_out = bout_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;

endmodule

// File: tb/tb_rca_serial_sub.sv
// Directed bench for rca_serial_sub at n=4. Observed status is packed as
// {busy, done, b_out, d} and compared against hand-derived expectations.
module tb_rca_serial_sub;

    localparam int unsigned N = 4;
`ifdef RCA_SERIAL_SUB_CLAMP_EN
    localparam bit CLAMP = 1'b1;
`else
    localparam bit CLAMP = 1'b0;
`endif

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    logic [3:0] last_d;
    logic       last_b;

    rca_serial_sub_if #(.n(N)) bus ();

    rca_serial_sub #(.n(N)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] obs();
        return {bus.busy, bus.done, bus.b_out, bus.d};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.start = 1'b0;
        bus.x = 4'd0;
        bus.y = 4'd0;
        bus.b_in = 1'b0;
        tick();
        checks++;
        if (obs() !== 7'b0) begin
            errors++;
            $display("FAIL reset_state observed=%b expected=%b", obs(), 7'b0);
        end
        reset = 1'b0;
        last_d = 4'd0;
        last_b = 1'b0;
    endtask

    task automatic test_reset_start();
        reset = 1'b1;
        bus.start = 1'b1;
        bus.x = 4'd8;
        bus.y = 4'd1;
        tick();
        checks++;
        if (obs() !== 7'b0) begin
            errors++;
            $display("FAIL reset_with_start observed=%b expected=%b", obs(), 7'b0);
        end
        reset = 1'b0;
        bus.start = 1'b0;
        tick();
        checks++;
        if (obs() !== 7'b0) begin
            errors++;
            $display("FAIL start_ignored_under_reset observed=%b expected=%b", obs(), 7'b0);
        end
    endtask

    // One operation: accept, n RUN edges, DONE pulse, back to IDLE.
    task automatic test_op(input logic [3:0] xv, input logic [3:0] yv, input logic bv,
                           input logic [3:0] ed, input logic eb, input string nm);
        logic [6:0] exp_v;
        bus.x = xv;
        bus.y = yv;
        bus.b_in = bv;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.x = ~xv;
        bus.y = ~yv;
        bus.b_in = ~bv;
        for (int k = 0; k <= N; k++) begin
            if (k < N) exp_v = {1'b1, 1'b0, last_b, last_d};
            else       exp_v = {1'b0, 1'b1, eb, ed};
            checks++;
            if (obs() !== exp_v) begin
                errors++;
                $display("FAIL %s cycle%0d observed=%b expected=%b", nm, k, obs(), exp_v);
            end
            if (k < N) tick();
        end
        last_d = ed;
        last_b = eb;
        tick();
        exp_v = {1'b0, 1'b0, last_b, last_d};
        checks++;
        if (obs() !== exp_v) begin
            errors++;
            $display("FAIL %s idle_after observed=%b expected=%b", nm, obs(), exp_v);
        end
    endtask

    task automatic test_back_to_back();
        logic [6:0] exp_v;
        logic [3:0] d2;
        d2 = CLAMP ? 4'd0 : 4'd11;
        bus.x = 4'd6;
        bus.y = 4'd1;
        bus.b_in = 1'b0;
        bus.start = 1'b1;
        tick();
        bus.x = 4'd2;
        bus.y = 4'd7;
        for (int j = 1; j <= 10; j++) begin
            if (j <= 3)       exp_v = {1'b1, 1'b0, last_b, last_d};
            else if (j == 4)  exp_v = {1'b0, 1'b1, 1'b0, 4'd5};
            else if (j <= 8)  exp_v = {1'b1, 1'b0, 1'b0, 4'd5};
            else if (j == 9)  exp_v = {1'b0, 1'b1, 1'b1, d2};
            else              exp_v = {1'b0, 1'b0, 1'b1, d2};
            tick();
            checks++;
            if (obs() !== exp_v) begin
                errors++;
                $display("FAIL back_to_back edge+%0d observed=%b expected=%b", j, obs(), exp_v);
            end
            if (j == 9) bus.start = 1'b0;
        end
        last_d = d2;
        last_b = 1'b1;
    endtask

    task automatic test_hold();
        logic [6:0] exp_v;
        exp_v = {1'b0, 1'b0, last_b, last_d};
        bus.start = 1'b0;
        for (int j = 0; j < 10; j++) begin
            bus.x = 4'($urandom_range(0, 15));
            bus.y = 4'($urandom_range(0, 15));
            bus.b_in = 1'($urandom_range(0, 1));
            tick();
            checks++;
            if (obs() !== exp_v) begin
                errors++;
                $display("FAIL hold cycle%0d observed=%b expected=%b", j, obs(), exp_v);
            end
        end
    endtask

    task automatic test_reset_abort();
        logic [6:0] exp_v;
        bus.x = 4'd12;
        bus.y = 4'd1;
        bus.b_in = 1'b0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        exp_v = {1'b1, 1'b0, last_b, last_d};
        checks++;
        if (obs() !== exp_v) begin
            errors++;
            $display("FAIL abort_running observed=%b expected=%b", obs(), exp_v);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        last_d = 4'd0;
        last_b = 1'b0;
        for (int j = 0; j < 6; j++) begin
            checks++;
            if (obs() !== 7'b0) begin
                errors++;
                $display("FAIL abort_no_done cycle%0d observed=%b expected=%b", j, obs(), 7'b0);
            end
            tick();
        end
        test_op(4'd9, 4'd4, 1'b0, 4'd5, 1'b0, "after_abort_9m4");
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_reset_start();
        test_op(4'd5,  4'd3,  1'b0, 4'd2, 1'b0, "op_5m3");
        test_op(4'd3,  4'd5,  1'b0, CLAMP ? 4'd0 : 4'd14, 1'b1, "op_3m5");
        test_op(4'd0,  4'd0,  1'b1, CLAMP ? 4'd0 : 4'd15, 1'b1, "op_0m0m1");
        test_op(4'd15, 4'd15, 1'b0, 4'd0, 1'b0, "op_15m15");
        test_op(4'd7,  4'd2,  1'b1, 4'd4, 1'b0, "op_7m2m1");
        test_back_to_back();
        test_hold();
        test_reset_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
